// File: rtl/sccb_target.sv
// sccb_target: camera-side SCCB responder with a 256x8 register file.
// Decodes START/STOP, 3-phase writes (ID, ADDR, DATA) and 2-phase reads
// (ID, DATA). It samples sio_c/sio_d on sccb_clk and never uses sio_c as a clock.
// The host port preloads and inspects the register file.
// Optional build macro SCCB_TARGET_ACK_EN: when it is defined, the target pulls
// sio_d low during bit 9 of a matching ID frame, of the ADDR frame and of the
// WDATA frame, in the manner of an I2C ACK. When it is undefined, bit 9 is released.
module sccb_target #(
  parameter logic [6:0] DEVICE_ID = 7'h21
) (
  input  logic       sccb_clk,
  input  logic       sccb_reset_n,
  input  logic       sio_c,
  inout  wire        sio_d,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       reg_wr_stb,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ID     = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  // Bus pins: index 0 is sio_c and index 1 is sio_d.
  logic [1:0] pin_raw;
  logic [1:0] sync0_q;
  logic [1:0] sync1_q;
  logic [1:0] prev_q;

  assign pin_raw = {sio_d, sio_c};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      // Two-flop synchroniser plus a delayed copy for edge detection.
      // The reset value matches the idle-high bus, so leaving reset creates no edge.
      always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
        if (!sccb_reset_n) begin
          sync0_q[gi] <= 1'b1;
          sync1_q[gi] <= 1'b1;
          prev_q[gi]  <= 1'b1;
        end else begin
          sync0_q[gi] <= pin_raw[gi];
          sync1_q[gi] <= sync0_q[gi];
          prev_q[gi]  <= sync1_q[gi];
        end
      end
    end
  endgenerate

  logic sc, sd, sc_prev, sd_prev;
  logic sc_rise, sc_fall, start_det, stop_det;

  assign sc        = sync1_q[0];
  assign sd        = sync1_q[1];
  assign sc_prev   = prev_q[0];
  assign sd_prev   = prev_q[1];
  assign sc_rise   = sc & ~sc_prev;
  assign sc_fall   = ~sc & sc_prev;
  // A data transition while the clock is stable high is framing, not a bit.
  assign start_det = sc & sc_prev & sd_prev & ~sd;
  assign stop_det  = sc & sc_prev & ~sd_prev & sd;

  logic [2:0] state_q,    state_d;
  logic [3:0] bit_cnt_q,  bit_cnt_d;
  logic [6:0] shift_q,    shift_d;
  logic [7:0] addr_ptr_q, addr_ptr_d;
  logic       rw_q,       rw_d;
  logic [7:0] tx_q,       tx_d;
  logic       oe_q,       oe_d;
  logic       do_q,       do_d;
  logic       wr_stb_q,   wr_stb_d;
  logic [7:0] wr_addr_q,  wr_addr_d;
  logic [7:0] wr_data_q,  wr_data_d;
  logic [7:0] byte_now;

  logic [7:0] regfile_q [256];

  // Byte as it stands once the bit currently being sampled is included.
  assign byte_now = {shift_q, sd};

  // Next-state logic for the protocol FSM, the bit counter and the pin driver.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_ptr_d = addr_ptr_q;
    rw_d       = rw_q;
    tx_d       = tx_q;
    oe_d       = oe_q;
    do_d       = do_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (start_det) begin
      // A repeated START abandons whatever was in progress.
      state_d   = ST_ID;
      bit_cnt_d = 4'd0;
      oe_d      = 1'b0;
    end else if (stop_det) begin
      // A partial byte is dropped. Nothing is written.
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      oe_d      = 1'b0;
    end else if (sc_rise && (state_q != ST_IDLE)) begin
      if (bit_cnt_q == 4'd8) begin
        // Ninth bit (don't-care/ACK): move to the next phase.
        bit_cnt_d = 4'd0;
        case (state_q)
          ST_ID: begin
            if (rw_q) begin
              state_d = ST_RDATA;
              // Latch the byte now, so later host writes cannot corrupt it.
              tx_d    = regfile_q[addr_ptr_q];
            end else begin
              state_d = ST_ADDR;
            end
          end
          ST_ADDR:  state_d = ST_WDATA;
          ST_WDATA: state_d = ST_IGNORE;
          ST_RDATA: state_d = ST_IGNORE;
          default:  state_d = state_q;
        endcase
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = byte_now[6:0];
        if (bit_cnt_q == 4'd7) begin
          case (state_q)
            ST_ID: begin
              if (byte_now[7:1] != DEVICE_ID) begin
                state_d = ST_IGNORE;
              end else begin
                rw_d = byte_now[0];
              end
            end
            ST_ADDR: addr_ptr_d = byte_now;
            ST_WDATA: begin
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_ptr_q;
              wr_data_d = byte_now;
            end
            default: ;
          endcase
        end
      end
    end else if (sc_fall) begin
      // The pin changes only while the clock is low.
      oe_d = 1'b0;
      do_d = 1'b1;
      if ((state_q == ST_RDATA) && (bit_cnt_q < 4'd8)) begin
        oe_d = 1'b1;
        do_d = tx_q[7];
        tx_d = {tx_q[6:0], 1'b0};
      end
`ifdef SCCB_TARGET_ACK_EN
      else if (((state_q == ST_ID) || (state_q == ST_ADDR) || (state_q == ST_WDATA)) &&
               (bit_cnt_q == 4'd8)) begin
        // ID mismatch has already moved to IGNORE, so ID here means a match.
        oe_d = 1'b1;
        do_d = 1'b0;
      end
`endif
    end
  end

  // Protocol state registers. Reset releases the pin at once.
  always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
    if (!sccb_reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 7'd0;
      addr_ptr_q <= 8'h00;
      rw_q       <= 1'b0;
      tx_q       <= 8'h00;
      oe_q       <= 1'b0;
      do_q       <= 1'b1;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_ptr_q <= addr_ptr_d;
      rw_q       <= rw_d;
      tx_q       <= tx_d;
      oe_q       <= oe_d;
      do_q       <= do_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Register file. If the host and SCCB write the same address, SCCB lands last and wins.
  always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
    if (!sccb_reset_n) begin
      for (int i = 0; i < 256; i++) begin
        regfile_q[i] <= 8'h00;
      end
    end else begin
      if (host_we) begin
        regfile_q[host_addr] <= host_wdata;
      end
      if (wr_stb_d) begin
        regfile_q[wr_addr_d] <= wr_data_d;
      end
    end
  end

  assign host_rdata  = regfile_q[host_addr];
  assign reg_wr_stb  = wr_stb_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = (state_q != ST_IDLE);
  assign sio_d       = oe_q ? do_q : 1'bz;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed SCCB transactions with scoreboard monitors for
// committed writes and for read bytes seen on the bus.
module tb_sccb_target;

  localparam int HALF = 8;

  logic       clk;
  logic       sccb_reset_n;
  logic       m_scl;
  logic       m_sda_low;
  wire        sio_d;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       reg_wr_stb;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       busy;

  // Open-drain initiator with a bus pull-up.
  assign sio_d = m_sda_low ? 1'b0 : 1'bz;
  pullup (sio_d);

  sccb_target dut (
    .sccb_clk     (clk),
    .sccb_reset_n (sccb_reset_n),
    .sio_c        (m_scl),
    .sio_d        (sio_d),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata),
    .reg_wr_stb   (reg_wr_stb),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int drv_low_cnt = 0;
  logic rd_window = 1'b0;
  logic allow_drive = 1'b0;
  logic [15:0] exp_wr[$];
  logic [8:0]  exp_rd[$];
  logic [8:0]  rd_bits = 9'd0;
  int          rd_n = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: each commit strobe pops one expected (addr,data) pair.
  always @(negedge clk) begin
    if (sccb_reset_n && reg_wr_stb) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got addr=0x%0h data=0x%0h expected no commit", reg_wr_addr, reg_wr_data);
      end else begin
        logic [15:0] e;
        e = exp_wr.pop_front();
        if ({reg_wr_addr, reg_wr_data} !== e) begin
          failures++;
          $display("FAIL wr_commit: got 0x%0h expected 0x%0h", {reg_wr_addr, reg_wr_data}, e);
        end else begin
          $display("wr commit addr=0x%0h data=0x%0h", reg_wr_addr, reg_wr_data);
        end
      end
    end
  end

  // Read monitor: collect 9 bus bits per read frame and compare with the expected byte plus a released bit 9.
  always @(posedge m_scl) begin
    if (rd_window) begin
      rd_bits = {rd_bits[7:0], sio_d};
      rd_n++;
      if (rd_n == 9) begin
        rd_n = 0;
        checks++;
        if (exp_rd.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected: got 0x%0h expected no read", rd_bits);
        end else begin
          logic [8:0] e;
          e = exp_rd.pop_front();
          if (rd_bits !== e) begin
            failures++;
            $display("FAIL rd_byte: got 0x%0h expected 0x%0h", rd_bits, e);
          end else begin
            $display("rd byte=0x%0h then released", rd_bits[8:1]);
          end
        end
      end
    end
  end

  // Flag any low level on sio_d that the initiator did not cause, outside read windows.
  always @(negedge clk) begin
    if (sccb_reset_n && !allow_drive && !m_sda_low && (sio_d === 1'b0)) begin
      drv_low_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0;
    wait_clk(HALF);
    m_scl = 1'b1;
    wait_clk(HALF);
    m_sda_low = 1'b1;
    wait_clk(HALF);
    m_scl = 1'b0;
    wait_clk(2);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1;
    wait_clk(HALF);
    m_scl = 1'b1;
    wait_clk(HALF);
    m_sda_low = 1'b0;
    wait_clk(HALF);
  endtask

  // One clock pulse. With hit set, a host write strobe is aligned to the target's sample cycle.
  task automatic send_bit(input logic b, input logic hit);
    m_sda_low = ~b;
    wait_clk(HALF - 2);
    m_scl = 1'b1;
    if (hit) begin
      wait_clk(2);
      host_we = 1'b1;
      wait_clk(1);
      host_we = 1'b0;
      wait_clk(HALF - 3);
    end else begin
      wait_clk(HALF);
    end
    m_scl = 1'b0;
    wait_clk(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic hit_last);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], hit_last && (i == 0));
    end
    send_bit(1'b1, 1'b0);
  endtask

  task automatic read_byte(input logic [7:0] exp);
    exp_rd.push_back({exp, 1'b1});
    rd_window = 1'b1;
    allow_drive = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send_bit(1'b1, 1'b0);
    end
    rd_window = 1'b0;
    allow_drive = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_addr = a;
    host_wdata = d;
    host_we = 1'b1;
    wait_clk(1);
    host_we = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [7:0] a, input logic [7:0] exp);
    host_addr = a;
    #1;
    check(name, 16'(host_rdata), 16'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sccb_reset_n = 1'b0;
    m_scl = 1'b1;
    m_sda_low = 1'b0;
    host_we = 1'b0;
    host_addr = 8'h00;
    host_wdata = 8'h00;
    wait_clk(5);
    sccb_reset_n = 1'b1;
    wait_clk(4);

    // Reset state
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_stb", 16'(reg_wr_stb), 16'd0);
    check("rst_wr_addr", 16'(reg_wr_addr), 16'd0);
    check("rst_wr_data", 16'(reg_wr_data), 16'd0);
    check("rst_sio_d", 16'(sio_d), 16'd1);
    check_reg("rst_reg12", 8'h12, 8'h00);

    // 3-phase write 0x42,0x12,0x80
    $display("txn write 0x42 0x12 0x80");
    exp_wr.push_back({8'h12, 8'h80});
    bus_start();
    check("busy_after_start", 16'(busy), 16'd1);
    send_byte(8'h42, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h80, 1'b0);
    bus_stop();
    check("busy_after_stop", 16'(busy), 16'd0);
    check_reg("reg12_written", 8'h12, 8'h80);

    // Host preload, then a 2-phase read of 0x0A
    $display("txn host 0x0A<=0x76, then read 0x0A");
    host_write(8'h0A, 8'h76);
    check_reg("host_reg0a", 8'h0A, 8'h76);
    bus_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'h0A, 1'b0);
    bus_stop();
    bus_start();
    send_byte(8'h43, 1'b0);
    read_byte(8'h76);
    bus_stop();

    // Foreign ID: the target must stay silent
    $display("txn foreign id 0x60 0x12 0x55");
    bus_start();
    send_byte(8'h60, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h55, 1'b0);
    check("foreign_busy", 16'(busy), 16'd1);
    check("foreign_no_drive", 16'(drv_low_cnt), 16'd0);
    bus_stop();
    check("foreign_idle", 16'(busy), 16'd0);
    check_reg("foreign_reg12", 8'h12, 8'h80);

    // STOP after 4 address bits: address pointer stays at 0x0A
    $display("txn stop after 4 address bits");
    bus_start();
    send_byte(8'h42, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    bus_stop();
    check("partial_idle", 16'(busy), 16'd0);
    check("partial_released", 16'(sio_d), 16'd1);
    bus_start();
    send_byte(8'h43, 1'b0);
    read_byte(8'h76);
    bus_stop();

    // Same-cycle collision on 0x12: the SCCB write wins
    $display("txn collision host 0x12<=0x11 vs sccb 0x12<=0x22");
    host_addr = 8'h12;
    host_wdata = 8'h11;
    exp_wr.push_back({8'h12, 8'h22});
    bus_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h22, 1'b1);
    bus_stop();
    check_reg("collide_same", 8'h12, 8'h22);

    // Same cycle, different addresses: both writes commit
    $display("txn host 0x13<=0x33 with sccb 0x14<=0x44");
    host_addr = 8'h13;
    host_wdata = 8'h33;
    exp_wr.push_back({8'h14, 8'h44});
    bus_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'h44, 1'b1);
    bus_stop();
    check_reg("both_host", 8'h13, 8'h33);
    check_reg("both_sccb", 8'h14, 8'h44);

    // Reset during read bit 3 of register 0x20 (0x00)
    $display("txn reset during read");
    bus_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'h20, 1'b0);
    bus_stop();
    bus_start();
    send_byte(8'h43, 1'b0);
    allow_drive = 1'b1;
    m_sda_low = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    wait_clk(3);
    check("rd_bit3_driven", 16'(sio_d), 16'd0);
    sccb_reset_n = 1'b0;
    #1;
    check("reset_releases", 16'(sio_d), 16'd1);
    check("reset_busy", 16'(busy), 16'd0);
    wait_clk(4);
    sccb_reset_n = 1'b1;
    allow_drive = 1'b0;
    wait_clk(4);
    check_reg("reset_regfile", 8'h12, 8'h00);
    m_scl = 1'b1;
    wait_clk(HALF);

    $display("txn write 0x42 0x30 0x5A after reset");
    exp_wr.push_back({8'h30, 8'h5A});
    bus_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'h30, 1'b0);
    send_byte(8'h5A, 1'b0);
    bus_stop();
    check_reg("post_reset_write", 8'h30, 8'h5A);

    wait_clk(10);
    check("wr_queue_empty", 16'(exp_wr.size()), 16'd0);
    check("rd_queue_empty", 16'(exp_rd.size()), 16'd0);
    check("never_driven_final", 16'(drv_low_cnt), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
